// File: rtl/decoder_5to32_sync_if.sv
// Select bus for the registered 5-to-32 decoder.
// The master drives the register index and enable; the slave (the decoder)
// returns the 32 one-hot select lines, Y31 down to Y0.
interface decoder_5to32_sync_if;
  logic       Y31, Y30, Y29, Y28, Y27, Y26, Y25, Y24;
  logic       Y23, Y22, Y21, Y20, Y19, Y18, Y17, Y16;
  logic       Y15, Y14, Y13, Y12, Y11, Y10, Y9,  Y8;
  logic       Y7,  Y6,  Y5,  Y4,  Y3,  Y2,  Y1,  Y0;
  logic [4:0] I;
  logic       En;

  // Index source side (datapath control)
  modport master (
    input  Y31, Y30, Y29, Y28, Y27, Y26, Y25, Y24,
    input  Y23, Y22, Y21, Y20, Y19, Y18, Y17, Y16,
    input  Y15, Y14, Y13, Y12, Y11, Y10, Y9,  Y8,
    input  Y7,  Y6,  Y5,  Y4,  Y3,  Y2,  Y1,  Y0,
    output I,
    output En
  );

  // Decoder side
  modport slave (
    output Y31, Y30, Y29, Y28, Y27, Y26, Y25, Y24,
    output Y23, Y22, Y21, Y20, Y19, Y18, Y17, Y16,
    output Y15, Y14, Y13, Y12, Y11, Y10, Y9,  Y8,
    output Y7,  Y6,  Y5,  Y4,  Y3,  Y2,  Y1,  Y0,
    input  I,
    input  En
  );
endinterface

// File: rtl/decoder_5to32_sync.sv
// Registered 5-to-32 one-hot decoder for register-file select.
// Selects are flopped on clk, so every output has exactly one cycle of
// latency from I/En and there is no combinational path from inputs to Y.
// A synchronous reset clears all selects and overrides En and I.
module decoder_5to32_sync (
  decoder_5to32_sync_if.slave bus,
  input  logic                clk,
  input  logic                rst
);

  logic [31:0] sel_d;
  logic [31:0] sel_q;

  // Next-state decode: a single bit set at the index when enabled, else none.
  always_comb begin
    sel_d = '0;
    if (bus.En) begin
      sel_d[bus.I] = 1'b1;
    end
  end

  // Select register; reset wins over any decode so X on I/En cannot survive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.Y0  = sel_q[0];
  assign bus.Y1  = sel_q[1];
  assign bus.Y2  = sel_q[2];
  assign bus.Y3  = sel_q[3];
  assign bus.Y4  = sel_q[4];
  assign bus.Y5  = sel_q[5];
  assign bus.Y6  = sel_q[6];
  assign bus.Y7  = sel_q[7];
  assign bus.Y8  = sel_q[8];
  assign bus.Y9  = sel_q[9];
  assign bus.Y10 = sel_q[10];
  assign bus.Y11 = sel_q[11];
  assign bus.Y12 = sel_q[12];
  assign bus.Y13 = sel_q[13];
  assign bus.Y14 = sel_q[14];
  assign bus.Y15 = sel_q[15];
  assign bus.Y16 = sel_q[16];
  assign bus.Y17 = sel_q[17];
  assign bus.Y18 = sel_q[18];
  assign bus.Y19 = sel_q[19];
  assign bus.Y20 = sel_q[20];
  assign bus.Y21 = sel_q[21];
  assign bus.Y22 = sel_q[22];
  assign bus.Y23 = sel_q[23];
  assign bus.Y24 = sel_q[24];
  assign bus.Y25 = sel_q[25];
  assign bus.Y26 = sel_q[26];
  assign bus.Y27 = sel_q[27];
  assign bus.Y28 = sel_q[28];
  assign bus.Y29 = sel_q[29];
  assign bus.Y30 = sel_q[30];
  assign bus.Y31 = sel_q[31];

endmodule

// File: tb/tb_decoder_5to32_sync.sv
// Self-checking bench for decoder_5to32_sync: directed vector table plus
// hand-written sweep, latency, mid-stream reset and random sequences.
module tb_decoder_5to32_sync;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  decoder_5to32_sync_if dif ();

  decoder_5to32_sync dut (
    .bus (dif.slave),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [4:0]  i;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] y_vec();
    return {dif.Y31, dif.Y30, dif.Y29, dif.Y28, dif.Y27, dif.Y26, dif.Y25, dif.Y24,
            dif.Y23, dif.Y22, dif.Y21, dif.Y20, dif.Y19, dif.Y18, dif.Y17, dif.Y16,
            dif.Y15, dif.Y14, dif.Y13, dif.Y12, dif.Y11, dif.Y10, dif.Y9,  dif.Y8,
            dif.Y7,  dif.Y6,  dif.Y5,  dif.Y4,  dif.Y3,  dif.Y2,  dif.Y1,  dif.Y0};
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = y_vec();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got Y=%08h, required %08h", name, got, exp);
    end
    n_checks++;
    if ($countones(got) > 1) begin
      n_errors++;
      $display("FAIL %s onehot: got Y=%08h with %0d lines high, required at most 1",
               name, got, $countones(got));
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic en, input logic [4:0] i);
    @(negedge clk);
    rst    = r;
    dif.En = en;
    dif.I  = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    dif.En   = 1'b1;
    dif.I    = 5'd5;

    // rst, En, I, expected selects after the edge
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 5'd5,  32'h0000_0020};
    vecs[3]  = '{1'b0, 1'b0, 5'h1F, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 5'h0A, 32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b1, 5'h0A, 32'h0000_0400};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  32'h0000_0001};
    vecs[7]  = '{1'b0, 1'b1, 5'd31, 32'h8000_0000};
    vecs[8]  = '{1'b1, 1'b1, 5'd31, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 5'd16, 32'h0001_0000};
    vecs[10] = '{1'b0, 1'b1, 5'd15, 32'h0000_8000};
    vecs[11] = '{1'b0, 1'b0, 5'd15, 32'h0000_0000};

    for (int k = 0; k < 12; k++) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].i);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Sweep every index; Y0 and Y31 are the boundaries.
    for (int k = 0; k < 32; k++) begin
      logic [31:0] e;
      e = 32'h0;
      e[k] = 1'b1;
      step(1'b0, 1'b1, 5'(k));
      check($sformatf("sweep%0d", k), e);
    end

    // Latency: an index change between edges must not reach Y until the next edge.
    step(1'b0, 1'b1, 5'd3);
    check("lat_y3", 32'h0000_0008);
    @(negedge clk);
    dif.I = 5'd4;
    #2;
    check("lat_hold_y3", 32'h0000_0008);
    @(posedge clk);
    #1;
    check("lat_y4", 32'h0000_0010);

    // Reset pulse mid-sweep at I=0x13, then decode resumes from the current I.
    step(1'b0, 1'b1, 5'h12);
    check("mid_pre", 32'h0004_0000);
    step(1'b1, 1'b1, 5'h13);
    check("mid_rst", 32'h0000_0000);
    step(1'b0, 1'b1, 5'h13);
    check("mid_resume", 32'h0008_0000);
    step(1'b0, 1'b1, 5'h14);
    check("mid_next", 32'h0010_0000);

    // Random traffic against the reference decode.
    for (int k = 0; k < 1000; k++) begin
      logic        r;
      logic        en;
      logic [4:0]  i;
      logic [31:0] e;
      r  = ($urandom_range(99) < 5);
      en = 1'($urandom_range(1));
      i  = 5'($urandom_range(31));
      e  = (r || !en) ? 32'h0 : (32'h1 << i);
      step(r, en, i);
      check($sformatf("rand%0d", k), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
